// File: rtl/klotski_pkg.sv
// Shared board geometry, colour type and piece palette for the Klotski renderer.
package klotski_pkg;

   localparam int COLS   = 4;
   localparam int ROWS   = 5;
   localparam int NCELLS = 20;
   localparam int ID_W   = 4;

   typedef logic [23:0]     rgb_t;
   typedef logic [ID_W-1:0] cell_id_t;

   localparam rgb_t RGB_BLACK = 24'h000000;
   localparam rgb_t RGB_WHITE = 24'hFFFFFF;
   localparam rgb_t RGB_EMPTY = 24'h202020;

   // Ids 11..15 are never issued by game logic, so they show as magenta.
   function automatic rgb_t id_to_rgb(input cell_id_t id);
      rgb_t c;
      case (id)
         4'd1:    c = 24'hCC2020;
         4'd2:    c = 24'h2060CC;
         4'd3:    c = 24'h20A040;
         4'd4:    c = 24'hD0A020;
         4'd5:    c = 24'h8040C0;
         4'd6:    c = 24'h20B0B0;
         4'd7:    c = 24'hC06020;
         4'd8:    c = 24'h6080A0;
         4'd9:    c = 24'hA0A0A0;
         4'd10:   c = 24'h40C080;
         default: c = 24'hFF00FF;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/klotski_board_regs.sv
// Shadow/active board storage with frame-synchronous commit and cursor blink timer.
module klotski_board_regs
   import klotski_pkg::*;
#(
   parameter int BLINK_FRAMES = 30
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_frame_start,
   input  logic       i_cell_valid,
   input  logic [4:0] i_cell_idx,
   input  cell_id_t   i_cell_id,
   output logic       o_cell_ready,
   input  logic       i_commit,
   output cell_id_t   o_active [NCELLS],
   output logic       o_blink
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   cell_id_t           shadow [NCELLS];
   logic               commit_pending;
   logic [CNT_W-1:0]   blink_cnt;

   assign o_cell_ready = !commit_pending;

   // Writes are refused while a commit waits, so the committed snapshot stays frozen.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NCELLS; i++) shadow[i] <= '0;
      end else if (i_cell_valid && o_cell_ready && (i_cell_idx < 5'(NCELLS))) begin
         shadow[i_cell_idx] <= i_cell_id;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NCELLS; i++) o_active[i] <= '0;
         commit_pending <= 1'b0;
      end else if (i_frame_start && commit_pending) begin
         o_active       <= shadow;
         commit_pending <= 1'b0;
      end else if (i_commit) begin
         commit_pending <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         blink_cnt <= '0;
         o_blink   <= 1'b0;
      end else if (i_frame_start) begin
         if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            o_blink   <= ~o_blink;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/klotski_board_renderer.sv
// Two-stage pixel colour pipeline drawing the Klotski board ahead of the VGA output stage.
module klotski_board_renderer
   import klotski_pkg::*;
#(
   parameter int X0           = 160,
   parameter int Y0           = 40,
   parameter int CELL         = 80,
   parameter int BORDER       = 3,
   parameter int BLINK_FRAMES = 30
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [9:0] i_x,
   input  logic [8:0] i_y,
   input  logic       i_de,
   input  logic       i_frame_start,
   input  logic       i_cell_valid,
   input  logic [4:0] i_cell_idx,
   input  logic [3:0] i_cell_id,
   output logic       o_cell_ready,
   input  logic       i_commit,
   input  logic       i_sel_en,
   input  logic [4:0] i_sel_idx,
   output logic       o_de,
   output logic [7:0] o_r,
   output logic [7:0] o_g,
   output logic [7:0] o_b
);

   cell_id_t active [NCELLS];
   logic     blink;

   klotski_board_regs #(.BLINK_FRAMES(BLINK_FRAMES)) u_board_regs (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_frame_start (i_frame_start),
      .i_cell_valid  (i_cell_valid),
      .i_cell_idx    (i_cell_idx),
      .i_cell_id     (i_cell_id),
      .o_cell_ready  (o_cell_ready),
      .i_commit      (i_commit),
      .o_active      (active),
      .o_blink       (blink)
   );

   logic [9:0] dx;
   logic [8:0] dy;
   logic [9:0] x_base;
   logic [8:0] y_base;
   logic [1:0] col;
   logic [2:0] row;
   logic       in_board;

   assign dx = i_x - 10'(X0);
   assign dy = i_y - 9'(Y0);
   assign in_board = (i_x >= 10'(X0)) && (i_x < 10'(X0 + COLS * CELL)) &&
                     (i_y >= 9'(Y0))  && (i_y < 9'(Y0 + ROWS * CELL));

   // Compare chains stand in for a divide by CELL; row/col stay in range even off-board.
   always_comb begin
      col    = 2'd0;
      x_base = '0;
      if      (dx >= 10'(3 * CELL)) begin col = 2'd3; x_base = 10'(3 * CELL); end
      else if (dx >= 10'(2 * CELL)) begin col = 2'd2; x_base = 10'(2 * CELL); end
      else if (dx >= 10'(CELL))     begin col = 2'd1; x_base = 10'(CELL);     end
      row    = 3'd0;
      y_base = '0;
      if      (dy >= 9'(4 * CELL)) begin row = 3'd4; y_base = 9'(4 * CELL); end
      else if (dy >= 9'(3 * CELL)) begin row = 3'd3; y_base = 9'(3 * CELL); end
      else if (dy >= 9'(2 * CELL)) begin row = 3'd2; y_base = 9'(2 * CELL); end
      else if (dy >= 9'(CELL))     begin row = 3'd1; y_base = 9'(CELL);     end
   end

   logic       s1_de, s1_in_board, s1_sel_en;
   logic [1:0] s1_col;
   logic [2:0] s1_row;
   logic [6:0] s1_xo, s1_yo;
   logic [4:0] s1_sel_idx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_de       <= 1'b0;
         s1_in_board <= 1'b0;
         s1_col      <= '0;
         s1_row      <= '0;
         s1_xo       <= '0;
         s1_yo       <= '0;
         s1_sel_en   <= 1'b0;
         s1_sel_idx  <= '0;
      end else begin
         s1_de       <= i_de;
         s1_in_board <= in_board;
         s1_col      <= col;
         s1_row      <= row;
         s1_xo       <= 7'(dx - x_base);
         s1_yo       <= 7'(dy - y_base);
         s1_sel_en   <= i_sel_en;
         s1_sel_idx  <= i_sel_idx;
      end
   end

   logic [4:0] cell_idx;
   cell_id_t   id;
   logic       left_diff, right_diff, up_diff, down_diff, outline, cursor;
   rgb_t       base_rgb, pix_rgb;

   // With COLS=4 the row-major index is simply {row, col}.
   assign cell_idx = {s1_row, s1_col};
   assign id       = active[cell_idx];

   always_comb begin
      left_diff  = (s1_col == 2'd0) || (active[cell_idx - 5'd1] != id);
      right_diff = (s1_col == 2'd3) || (active[cell_idx + 5'd1] != id);
      up_diff    = (s1_row == 3'd0) || (active[cell_idx - 5'd4] != id);
      down_diff  = (s1_row == 3'd4) || (active[cell_idx + 5'd4] != id);
      outline    = ((s1_xo < 7'(BORDER))        && left_diff)  ||
                   ((s1_xo >= 7'(CELL - BORDER)) && right_diff) ||
                   ((s1_yo < 7'(BORDER))        && up_diff)    ||
                   ((s1_yo >= 7'(CELL - BORDER)) && down_diff);
      cursor     = s1_sel_en && blink && s1_in_board && (cell_idx == s1_sel_idx);

      if      (!s1_in_board) base_rgb = RGB_BLACK;
      else if (outline)      base_rgb = RGB_WHITE;
      else if (id == '0)     base_rgb = RGB_EMPTY;
      else                   base_rgb = id_to_rgb(id);

      pix_rgb = cursor ? ~base_rgb : base_rgb;
      if (!s1_de) pix_rgb = RGB_BLACK;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_de <= 1'b0;
         o_r  <= '0;
         o_g  <= '0;
         o_b  <= '0;
      end else begin
         o_de <= s1_de;
         o_r  <= pix_rgb[23:16];
         o_g  <= pix_rgb[15:8];
         o_b  <= pix_rgb[7:0];
      end
   end

endmodule

// File: tb/tb_klotski_board_renderer.sv
// Directed bench for klotski_board_renderer: handshake, commit timing, outlines, palette, cursor blink.
module tb_klotski_board_renderer;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic [9:0] i_x = '0;
   logic [8:0] i_y = '0;
   logic       i_de = 1'b0;
   logic       i_frame_start = 1'b0;
   logic       i_cell_valid = 1'b0;
   logic [4:0] i_cell_idx = '0;
   logic [3:0] i_cell_id = '0;
   logic       o_cell_ready;
   logic       i_commit = 1'b0;
   logic       i_sel_en = 1'b0;
   logic [4:0] i_sel_idx = '0;
   logic       o_de;
   logic [7:0] o_r, o_g, o_b;

   int testCount = 0;
   int failCount = 0;
   int frameCount = 0;

   klotski_board_renderer dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_x           (i_x),
      .i_y           (i_y),
      .i_de          (i_de),
      .i_frame_start (i_frame_start),
      .i_cell_valid  (i_cell_valid),
      .i_cell_idx    (i_cell_idx),
      .i_cell_id     (i_cell_id),
      .o_cell_ready  (o_cell_ready),
      .i_commit      (i_commit),
      .i_sel_en      (i_sel_en),
      .i_sel_idx     (i_sel_idx),
      .o_de          (o_de),
      .o_r           (o_r),
      .o_g           (o_g),
      .o_b           (o_b)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic expDe, input logic [23:0] expRgb);
      testCount++;
      assert ({o_de, o_r, o_g, o_b} === {expDe, expRgb})
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed de=%0b rgb=%h, expected de=%0b rgb=%h",
                tag, o_de, {o_r, o_g, o_b}, expDe, expRgb);
      end
   endtask

   task automatic checkReady(input string tag, input logic expReady);
      testCount++;
      assert (o_cell_ready === expReady)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed ready=%0b, expected ready=%0b", tag, o_cell_ready, expReady);
      end
   endtask

   // Present one pixel and sample the result two clock edges later.
   task automatic applyStimulus(input int x, input int y, input logic de);
      @(negedge i_clk);
      i_x  = 10'(x);
      i_y  = 9'(y);
      i_de = de;
      @(posedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic writeCell(input int idx, input int id, input logic withCommit);
      @(negedge i_clk);
      i_cell_valid = 1'b1;
      i_cell_idx   = 5'(idx);
      i_cell_id    = 4'(id);
      i_commit     = withCommit;
      @(negedge i_clk);
      i_cell_valid = 1'b0;
      i_commit     = 1'b0;
   endtask

   task automatic commitPulse();
      @(negedge i_clk);
      i_commit = 1'b1;
      @(negedge i_clk);
      i_commit = 1'b0;
   endtask

   task automatic frameStart();
      @(negedge i_clk);
      i_frame_start = 1'b1;
      @(negedge i_clk);
      i_frame_start = 1'b0;
      frameCount++;
   endtask

   initial begin
      logic [23:0] expBlink;

      // Reset state
      #12;
      checkOutput("reset_outputs", 1'b0, 24'h000000);
      checkReady("reset_ready", 1'b1);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Latency: o_de not yet up after one edge, up after two
      @(negedge i_clk);
      i_x = '0; i_y = '0; i_de = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("latency_one_cycle", 1'b0, 24'h000000);
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("offboard_origin", 1'b1, 24'h000000);
      checkReady("ready_idle", 1'b1);

      // Two id-1 cells side by side
      writeCell(0, 1, 1'b0);
      writeCell(1, 1, 1'b0);
      commitPulse();
      frameStart();
      applyStimulus(200, 100, 1'b1);
      checkOutput("cell0_body", 1'b1, 24'hCC2020);
      applyStimulus(240, 100, 1'b1);
      checkOutput("no_outline_same_id", 1'b1, 24'hCC2020);
      applyStimulus(160, 100, 1'b1);
      checkOutput("left_board_edge", 1'b1, 24'hFFFFFF);
      applyStimulus(200, 100, 1'b0);
      checkOutput("de_low_black", 1'b0, 24'h000000);

      // Write and commit in one cycle; display holds until frame start
      writeCell(5, 2, 1'b1);
      checkReady("ready_low_pending", 1'b0);
      applyStimulus(260, 140, 1'b1);
      checkOutput("before_swap_empty", 1'b1, 24'h202020);
      frameStart();
      checkReady("ready_after_swap", 1'b1);
      applyStimulus(260, 140, 1'b1);
      checkOutput("after_swap_piece", 1'b1, 24'h2060CC);
      applyStimulus(260, 119, 1'b1);
      checkOutput("outline_vertical_diff", 1'b1, 24'hFFFFFF);

      // Write held while a commit is pending
      commitPulse();
      @(negedge i_clk);
      i_cell_valid = 1'b1;
      i_cell_idx   = 5'd2;
      i_cell_id    = 4'd3;
      @(negedge i_clk);
      checkReady("held_write_blocked", 1'b0);
      @(negedge i_clk);
      i_frame_start = 1'b1;
      @(negedge i_clk);
      i_frame_start = 1'b0;
      frameCount++;
      checkReady("held_write_ready", 1'b1);
      @(negedge i_clk);
      i_cell_valid = 1'b0;
      applyStimulus(360, 100, 1'b1);
      checkOutput("held_write_not_in_swap", 1'b1, 24'h202020);
      commitPulse();
      frameStart();
      applyStimulus(360, 100, 1'b1);
      checkOutput("held_write_committed", 1'b1, 24'h20A040);
      applyStimulus(319, 100, 1'b1);
      checkOutput("outline_right_diff", 1'b1, 24'hFFFFFF);

      // Out-of-range index discarded; error palette entry
      writeCell(25, 4, 1'b0);
      checkReady("idx25_no_pending", 1'b1);
      writeCell(10, 11, 1'b0);
      commitPulse();
      frameStart();
      applyStimulus(260, 140, 1'b1);
      checkOutput("idx25_cell5_kept", 1'b1, 24'h2060CC);
      applyStimulus(360, 100, 1'b1);
      checkOutput("idx25_cell2_kept", 1'b1, 24'h20A040);
      applyStimulus(200, 100, 1'b1);
      checkOutput("idx25_cell0_kept", 1'b1, 24'hCC2020);
      applyStimulus(360, 240, 1'b1);
      checkOutput("error_palette", 1'b1, 24'hFF00FF);
      applyStimulus(100, 100, 1'b1);
      checkOutput("offboard_left", 1'b1, 24'h000000);

      // Cursor blink across two phase changes
      i_sel_en  = 1'b1;
      i_sel_idx = 5'd0;
      for (int f = 0; f < 60; f++) begin
         frameStart();
         applyStimulus(200, 100, 1'b1);
         expBlink = (((frameCount / 30) % 2) == 1) ? 24'h33DFDF : 24'hCC2020;
         checkOutput($sformatf("blink_frame_%0d", frameCount), 1'b1, expBlink);
      end
      applyStimulus(240, 100, 1'b1);
      checkOutput("cursor_other_cell", 1'b1, 24'hCC2020);

      // Mid-frame reset clears outputs immediately
      i_sel_en = 1'b0;
      applyStimulus(200, 100, 1'b1);
      checkOutput("pre_reset_pixel", 1'b1, 24'hCC2020);
      #2;
      i_rst_n = 1'b0;
      #1;
      checkOutput("midframe_reset", 1'b0, 24'h000000);
      checkReady("midframe_reset_ready", 1'b1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/klotski_board_renderer.md
Name: klotski_board_renderer

Overview:
- Pixel-colour source that sits directly upstream of the VGA timing/output stage.
- Takes the timing stage's pixel coordinates and data-enable, and returns the RGB for that pixel with a fixed 2-cycle latency.
- Renders the 4x5 Klotski board as coloured pieces with outlines and a blinking selection cursor.
- Board contents arrive from game logic through a cell-write handshake into a shadow copy; the shadow is committed to the displayed copy only at a frame boundary, so a frame never tears.

Parameters:
- X0, 160, left pixel column of the board
- Y0, 40, top pixel row of the board
- CELL, 80, cell edge length in pixels (board spans 320x400)
- BORDER, 3, outline thickness in pixels
- BLINK_FRAMES, 30, frames per cursor blink phase

Ports:
- i_clk  in  1  pixel-domain clock; all registers update on the rising edge
- i_rst_n  in  1  reset
- i_x  in  10  active-area pixel column, 0..639
- i_y  in  9  active-area pixel row, 0..479
- i_de  in  1  pixel active strobe
- i_frame_start  in  1  one-cycle pulse at start of vertical blanking
- i_cell_valid  in  1  cell write request
- i_cell_idx  in  5  cell index = row*4+col, 0..19
- i_cell_id  in  4  piece id, 0 = empty
- o_cell_ready  out  1  cell write accepted when valid&ready
- i_commit  in  1  one-cycle pulse: shadow board complete
- i_sel_en  in  1  cursor enable
- i_sel_idx  in  5  selected cell index
- o_de  out  1  i_de delayed 2 cycles
- o_r, o_g, o_b  out  8 each  pixel colour aligned to o_de

Behaviour:
- Reset: i_rst_n is asynchronous, active-low.
  - Registers cleared at reset: shadow and active boards all 0; commit_pending=0; blink counter=0; blink phase=0; pipeline registers 0.
  - Outputs at reset: o_de=0, o_r=o_g=o_b=0, o_cell_ready=1.
- Write handshake:
  - o_cell_ready = !commit_pending.
  - On valid&ready with idx<20, shadow[idx] <= id.
  - idx>=20 is accepted and discarded.
  - A write presented while ready=0 is not consumed; the producer holds it.
- Commit:
  - i_commit sets commit_pending. A commit already pending has no extra effect.
  - A write and a commit in the same cycle: the write lands in the shadow and is included in the commit.
  - On i_frame_start with commit_pending=1 (registered, so not the same cycle as the commit pulse): active <= shadow, commit_pending <= 0.
  - A commit arriving in the same cycle as i_frame_start waits for the next frame_start.
- Blink:
  - On each i_frame_start the counter increments.
  - At BLINK_FRAMES-1 the counter wraps to 0 and the blink phase toggles.
- Pipeline stage 1 (registered):
  - in_board = X0<=x<X0+4*CELL and Y0<=y<Y0+5*CELL.
  - col/row come from constant compare chains (no dividers).
  - xo = x-X0-col*CELL and yo = y-Y0-row*CELL, 7 bits each.
  - i_de is delayed alongside.
- Pipeline stage 2 (registered to outputs):
  - id = active[row*4+col].
  - Outline: the pixel is outline if any of the following holds:
    - xo<BORDER and the left neighbour is off-board or has a different id.
    - xo>=CELL-BORDER and the right neighbour is off-board or has a different id.
    - The same two rules applied vertically with yo and the up/down neighbours.
  - Colour precedence:
    - de=0 -> 000000.
    - !in_board -> 000000.
    - outline -> FFFFFF.
    - id=0 -> 202020.
    - otherwise palette[id].
  - Cursor: if i_sel_en, blink phase=1 and cell==i_sel_idx, the final RGB is bitwise inverted, except when de=0.
  - i_sel_en and i_sel_idx are sampled in stage 1.
- Latency: exactly 2 cycles from i_x/i_y/i_de to o_*, independent of content. No backpressure on the pixel path.
- Reset mid-frame: outputs drop to 0 immediately; the board must be rewritten and committed.

Decomposition:
- klotski_pkg holds:
  - Board constants: COLS=4, ROWS=5, NCELLS=20, ID_W=4.
  - Colour typedef rgb_t (24 bits).
  - Palette function id_to_rgb:
    - 1 = CC2020, 2 = 2060CC, 3 = 20A040, 4 = D0A020, 5 = 8040C0, 6 = 20B0B0, 7 = C06020, 8 = 6080A0, 9 = A0A0A0, 10 = 40C080.
    - 11..15 = FF00FF (error).
- Sub-module klotski_board_regs holds the shadow/active arrays, write handshake, commit logic and blink counter. The renderer top holds the 2-stage pixel pipeline.

Test Plan:
- Reset, drive de=1 at (0,0) -> o_de=1 two cycles later, RGB=000000; o_cell_ready=1.
- Write idx 0 id 1 and idx 1 id 1, commit, frame_start; pixel (200,100) -> CC2020; pixel (240,100) -> CC2020 (no outline between same-id cells); pixel (160,100) -> FFFFFF.
- Write idx 5 id 2 and commit in the same cycle -> o_cell_ready=0 next cycle. Pixel (260,140) stays 202020 until the next frame_start, then reads 2060CC; ready returns to 1.
- Hold i_cell_valid with idx 2 while pending -> not consumed; consumed in the cycle after the swap.
- Write idx 25 -> accepted; no cell changes after commit.
- i_sel_en=1, i_sel_idx=0 on a committed id-1 cell:
  - Frames 0..29 -> CC2020.
  - Frames 30..59 -> 33DFDF.
  - Frame 60 -> CC2020 again.
